// File: rtl/dtmf_tone_detector.sv
// -----------------------------------------------------------------------------
// dtmf_tone_detector
//
// Measures the period of an asynchronous square-wave tone against the 1 MHz
// system clock. Detection is asserted once MATCH_COUNT consecutive periods
// fall inside [PERIOD_MIN, PERIOD_MAX] (default window brackets 1209 Hz,
// i.e. about 830 cycles).
//
// Ports:
//   clk_1m_in     in   1 MHz system clock
//   reset_b       in   asynchronous active-low reset
//   tone_in       in   asynchronous square-wave tone
//   enable        in   synchronous enable; 0 forces IDLE
//   period_out    out  [11:0] last measured period, saturating at 4095
//   period_valid  out  one-cycle pulse when period_out updates
//   tone_detected out  level, tone present and locked
//   timeout       out  one-cycle pulse on loss of signal
//
// Optional build macro:
//   DTMF_MISS_TOLERANCE_EN  tolerate a single out-of-window period while
//                           locked; a second consecutive one drops the lock.
//
// State table:
//   S_IDLE    | counters held at 0, detection cleared, waiting for enable
//   S_ACQUIRE | waiting for the first rising edge; nothing is measured on it
//   S_MEASURE | counting cycles between rising edges, qualifying each period
// -----------------------------------------------------------------------------
module dtmf_tone_detector #(
    parameter int unsigned PERIOD_MIN     = 810,
    parameter int unsigned PERIOD_MAX     = 850,
    parameter int unsigned MATCH_COUNT    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2047
) (
    input  logic        clk_1m_in,
    input  logic        reset_b,
    input  logic        tone_in,
    input  logic        enable,
    output logic [11:0] period_out,
    output logic        period_valid,
    output logic        tone_detected,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam logic [11:0] C_MIN   = 12'(PERIOD_MIN);
    localparam logic [11:0] C_MAX   = 12'(PERIOD_MAX);
    localparam logic [3:0]  C_MATCH = 4'(MATCH_COUNT);
    localparam logic [11:0] C_TMO   = 12'(TIMEOUT_CYCLES);

    state_t      r_state, w_state_next;
    logic        r_sync1, r_sync2, r_sync3;
    logic        w_rise;
    logic [11:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [11:0] r_period, w_period_next;
    logic [3:0]  r_match, w_match_next, w_match_inc;
    logic        r_valid, w_valid_next;
    logic        r_det, w_det_next;
    logic        r_tmo, w_tmo_next;
    logic        w_in_window;
`ifdef DTMF_MISS_TOLERANCE_EN
    logic        r_miss, w_miss_next;
`endif

    always_ff @(posedge clk_1m_in or negedge reset_b) begin
        if (!reset_b) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= tone_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;

    // Saturating counter + 1 doubles as the measured period on a rise.
    assign w_cnt_inc   = (r_cnt == 12'hFFF) ? r_cnt : r_cnt + 12'd1;
    assign w_in_window = (w_cnt_inc >= C_MIN) && (w_cnt_inc <= C_MAX);
    assign w_match_inc = (r_match >= C_MATCH) ? C_MATCH : r_match + 4'd1;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_period_next = r_period;
        w_match_next  = r_match;
        w_valid_next  = 1'b0;
        w_tmo_next    = 1'b0;
        w_det_next    = r_det;
`ifdef DTMF_MISS_TOLERANCE_EN
        w_miss_next   = r_miss;
`endif
        if (!enable) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 12'd0;
            w_match_next = 4'd0;
            w_det_next   = 1'b0;
`ifdef DTMF_MISS_TOLERANCE_EN
            w_miss_next  = 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_next   = 12'd0;
                    w_match_next = 4'd0;
                    w_det_next   = 1'b0;
                    w_state_next = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (w_rise) begin
                        w_cnt_next   = 12'd0;
                        w_state_next = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    // A rise on the edge where the count would reach the
                    // timeout still counts as a period; the rise wins.
                    if (w_rise) begin
                        w_period_next = w_cnt_inc;
                        w_valid_next  = 1'b1;
                        w_cnt_next    = 12'd0;
                        if (w_in_window) begin
                            w_match_next = w_match_inc;
`ifdef DTMF_MISS_TOLERANCE_EN
                            w_miss_next  = 1'b0;
`endif
                        end else begin
`ifdef DTMF_MISS_TOLERANCE_EN
                            if (r_det && !r_miss) begin
                                w_miss_next = 1'b1;
                            end else begin
                                w_match_next = 4'd0;
                                w_miss_next  = 1'b0;
                            end
`else
                            w_match_next = 4'd0;
`endif
                        end
                        w_det_next = (w_match_next == C_MATCH);
                    end else if (w_cnt_inc == C_TMO) begin
                        w_tmo_next   = 1'b1;
                        w_cnt_next   = 12'd0;
                        w_match_next = 4'd0;
                        w_det_next   = 1'b0;
                        w_state_next = S_ACQUIRE;
`ifdef DTMF_MISS_TOLERANCE_EN
                        w_miss_next  = 1'b0;
`endif
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1m_in or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= S_IDLE;
            r_cnt    <= 12'd0;
            r_period <= 12'd0;
            r_match  <= 4'd0;
            r_valid  <= 1'b0;
            r_det    <= 1'b0;
            r_tmo    <= 1'b0;
`ifdef DTMF_MISS_TOLERANCE_EN
            r_miss   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_period <= w_period_next;
            r_match  <= w_match_next;
            r_valid  <= w_valid_next;
            r_det    <= w_det_next;
            r_tmo    <= w_tmo_next;
`ifdef DTMF_MISS_TOLERANCE_EN
            r_miss   <= w_miss_next;
`endif
        end
    end

    assign period_out    = r_period;
    assign period_valid  = r_valid;
    assign tone_detected = r_det;
    assign timeout       = r_tmo;

endmodule

// File: tb/tb_dtmf_tone_detector.sv
// -----------------------------------------------------------------------------
// tb_dtmf_tone_detector
//
// Directed bench for dtmf_tone_detector with default parameters
// (window 810..850, MATCH_COUNT 4, TIMEOUT_CYCLES 2047). Tone edges are
// placed on exact cycle counts so every measured period is known up front.
// -----------------------------------------------------------------------------
module tb_dtmf_tone_detector;

    logic        clk_1m_in = 1'b0;
    logic        reset_b   = 1'b0;
    logic        tone_in   = 1'b0;
    logic        enable    = 1'b0;
    logic [11:0] period_out;
    logic        period_valid;
    logic        tone_detected;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    // observations gathered just after each active edge
    int cyc          = 0;
    int n_valid      = 0;
    int n_timeout    = 0;
    int last_period  = 0;
    int det_at_valid = 0;
    int valid_cyc    = 0;
    int tmo_cyc      = 0;

    dtmf_tone_detector dut (
        .clk_1m_in     (clk_1m_in),
        .reset_b       (reset_b),
        .tone_in       (tone_in),
        .enable        (enable),
        .period_out    (period_out),
        .period_valid  (period_valid),
        .tone_detected (tone_detected),
        .timeout       (timeout)
    );

    always #5 clk_1m_in = ~clk_1m_in;

    always @(posedge clk_1m_in) begin
        #1;
        cyc = cyc + 1;
        if (period_valid) begin
            n_valid      = n_valid + 1;
            last_period  = int'(period_out);
            det_at_valid = int'(tone_detected);
            valid_cyc    = cyc;
        end
        if (timeout) begin
            n_timeout = n_timeout + 1;
            tmo_cyc   = cyc;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_1m_in);
        reset_b = 1'b0;
        enable  = 1'b0;
        tone_in = 1'b0;
        repeat (3) @(negedge clk_1m_in);
        check_eq("rst_period_out", int'(period_out), 0);
        check_eq("rst_valid", int'(period_valid), 0);
        check_eq("rst_det", int'(tone_detected), 0);
        check_eq("rst_timeout", int'(timeout), 0);
        reset_b = 1'b1;
        @(negedge clk_1m_in);
    endtask

    // One rising edge on tone_in followed by p cycles until the next one.
    task automatic send_period(input int p);
        int h;
        h = p / 2;
        tone_in = 1'b1;
        repeat (h) @(negedge clk_1m_in);
        tone_in = 1'b0;
        repeat (p - h) @(negedge clk_1m_in);
    endtask

    task automatic lock_830(input string tag);
        enable = 1'b1;
        @(negedge clk_1m_in);
        repeat (5) send_period(830);
        check_eq(tag, int'(tone_detected), 1);
    endtask

    initial begin
        int v0;
        int t0;
        int bnd_p[4];
        int bnd_d[4];
        bnd_p = '{809, 810, 850, 851};
        bnd_d = '{0, 1, 1, 0};

        // 1: 1209 Hz tone, detection on the 5th rising edge
        do_reset();
        enable = 1'b1;
        @(negedge clk_1m_in);
        v0 = n_valid;
        for (int i = 1; i <= 5; i++) begin
            send_period(830);
            check_eq("t1_nvalid", n_valid - v0, i - 1);
            check_eq("t1_det", int'(tone_detected), (i >= 5) ? 1 : 0);
        end
        check_eq("t1_period", last_period, 830);
        check_eq("t1_det_with_valid", det_at_valid, 1);
        send_period(830);
        check_eq("t1_det_holds", int'(tone_detected), 1);

        // 2: window boundaries
        for (int g = 0; g < 4; g++) begin
            do_reset();
            enable = 1'b1;
            @(negedge clk_1m_in);
            v0 = n_valid;
            repeat (6) send_period(bnd_p[g]);
            check_eq("t2_nvalid", n_valid - v0, 5);
            check_eq("t2_period", last_period, bnd_p[g]);
            check_eq("t2_det", int'(tone_detected), bnd_d[g]);
        end

        // 3: loss of signal, then longest period that still beats the timeout
        do_reset();
        lock_830("t3_locked");
        t0 = n_timeout;
        for (int k = 0; k < 3000 && n_timeout == t0; k++) @(negedge clk_1m_in);
        check_eq("t3_timeout_seen", int'(n_timeout != t0), 1);
        check_eq("t3_timeout_delay", tmo_cyc - valid_cyc, 2047);
        repeat (10) @(negedge clk_1m_in);
        check_eq("t3_timeout_once", n_timeout - t0, 1);
        check_eq("t3_det_after_tmo", int'(tone_detected), 0);
        v0 = n_valid;
        send_period(830);
        check_eq("t3_acquire_no_valid", n_valid - v0, 0);
        send_period(2047);
        tone_in = 1'b1;
        repeat (10) @(negedge clk_1m_in);
        check_eq("t3_nvalid_2047", n_valid - v0, 2);
        check_eq("t3_period_2047", int'(period_out), 2047);
        check_eq("t3_no_tmo_2047", n_timeout - t0, 1);
        tone_in = 1'b0;

        // 4: one short period while locked
        do_reset();
        lock_830("t4_locked");
        send_period(700);
        send_period(830);
        check_eq("t4_short_period", last_period, 700);
`ifdef DTMF_MISS_TOLERANCE_EN
        check_eq("t4_det_single_miss", int'(tone_detected), 1);
        send_period(700);
        send_period(700);
        check_eq("t4_det_after_miss1", int'(tone_detected), 1);
        send_period(830);
        check_eq("t4_det_after_miss2", int'(tone_detected), 0);
        check_eq("t4_short_period2", last_period, 700);
`else
        check_eq("t4_det_drop", int'(tone_detected), 0);
        repeat (3) send_period(830);
        check_eq("t4_det_3_good", int'(tone_detected), 0);
        send_period(830);
        check_eq("t4_det_4_good", int'(tone_detected), 1);
`endif

        // 5: asynchronous reset mid-period
        do_reset();
        lock_830("t5_locked");
        tone_in = 1'b1;
        repeat (415) @(negedge clk_1m_in);
        tone_in = 1'b0;
        repeat (200) @(negedge clk_1m_in);
        #2 reset_b = 1'b0;
        #1;
        check_eq("t5_async_period", int'(period_out), 0);
        check_eq("t5_async_det", int'(tone_detected), 0);
        check_eq("t5_async_valid", int'(period_valid), 0);
        check_eq("t5_async_timeout", int'(timeout), 0);
        repeat (5) @(negedge clk_1m_in);
        reset_b = 1'b1;
        repeat (215) @(negedge clk_1m_in);
        v0 = n_valid;
        send_period(830);
        check_eq("t5_first_edge", n_valid - v0, 0);
        send_period(830);
        check_eq("t5_second_edge", n_valid - v0, 1);
        check_eq("t5_period", last_period, 830);

        // 6: enable dropped while locked
        do_reset();
        lock_830("t6_locked");
        tone_in = 1'b1;
        repeat (100) @(negedge clk_1m_in);
        enable = 1'b0;
        repeat (10) @(negedge clk_1m_in);
        check_eq("t6_det_disabled", int'(tone_detected), 0);
        check_eq("t6_period_held", int'(period_out), 830);
        check_eq("t6_valid_disabled", int'(period_valid), 0);
        enable = 1'b1;
        repeat (305) @(negedge clk_1m_in);
        tone_in = 1'b0;
        repeat (415) @(negedge clk_1m_in);
        for (int i = 1; i <= 5; i++) begin
            send_period(830);
            if (i >= 4) check_eq("t6_det_reenable", int'(tone_detected), (i == 5) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
